// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder.
//   state_t    : control FSM states
//   NIBBLE_W   : width of one add slice
//   cnt_width  : width of the nibble counter for a given nibble count
package nsa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned NIBBLE_W = 4;

    // One spare bit so the counter can hold NIBBLES itself without wrapping.
    function automatic int unsigned cnt_width(input int unsigned nibbles);
        return $clog2(nibbles) + 1;
    endfunction

endpackage

// File: rtl/workshop.sv
// 4-bit ripple-carry adder, purely combinational.
//   a, b   : 4-bit addends
//   cin    : carry in
//   sum_c  : a + b + cin, low 4 bits
//   cout_c : carry out of bit 3
module workshop
    import nsa_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum_c,
    output logic                cout_c
);

    logic [NIBBLE_W:0] c;

    assign c[0] = cin;

    // One full adder per bit, carry rippling upward.
    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
        assign sum_c[i] = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout_c = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per clock, LS nibble first,
// through a single shared 4-bit ripple-carry adder.
//   clk, rst_n           : clock, async active-low reset
//   in_valid / in_ready  : operand handshake (ready only in IDLE)
//   in_a, in_b, in_cin   : operands and carry-in
//   out_valid / out_ready: result handshake
//   out_sum, out_cout    : A + B + cin as a WIDTH+1-bit unsigned sum
//   busy                 : operation in flight or result waiting
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
    localparam int unsigned CNT_W   = cnt_width(NIBBLES);

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   a_sh, b_sh, sum_sh;
    logic               carry;
    logic [CNT_W-1:0]   cnt;

    logic [NIBBLE_W-1:0] add_sum;
    logic                add_cout;

    logic accept;
    logic last_nibble;

    assign accept      = (state == IDLE) && in_valid;
    assign last_nibble = (cnt == CNT_W'(NIBBLES - 1));

    // Shared nibble adder.
    workshop u_add (
        .a      (a_sh[NIBBLE_W-1:0]),
        .b      (b_sh[NIBBLE_W-1:0]),
        .cin    (carry),
        .sum_c  (add_sum),
        .cout_c (add_cout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)    state_nxt = RUN;
            RUN:     if (last_nibble) state_nxt = DONE;
            DONE:    if (out_ready)   state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // Output decode; everything here comes straight from registers.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        out_sum   = '0;
        out_cout  = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            RUN:  busy     = 1'b1;
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_sum   = sum_sh;
                out_cout  = carry;
            end
            default: ;
        endcase
    end

    // Datapath: operand/sum shift registers, carry and nibble counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sh   <= in_a;
            b_sh   <= in_b;
            sum_sh <= '0;
            carry  <= in_cin;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> NIBBLE_W;
            b_sh   <= b_sh >> NIBBLE_W;
            // New nibble enters at the top; after NIBBLES steps it lands at bit 0.
            sum_sh <= WIDTH'({add_sum, sum_sh} >> NIBBLE_W);
            carry  <= add_cout;
            cnt    <= cnt + CNT_W'(1);
        end
    end

endmodule
